// File: rtl/decode_stage_fwd.sv
// ID pipeline stage: field decode, EX/MEM operand forwarding, load-use bubble
// insertion and the ID/EX boundary register with valid, stall and flush.
module decode_stage_fwd #(
  parameter int INST_W       = 16,
  parameter int DATA_W       = 16,
  parameter int OP_W         = 4,
  parameter int IDX_W        = 5,
  parameter int IMM_W        = 7,
  parameter int LOAD_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              VALID_IF,
  input  logic [DATA_W-1:0] NPC_IF,
  input  logic [INST_W-1:0] INST_IF,
  input  logic              BRANCH_PRED_IF,
  output logic [IDX_W-1:0]  read_index_1,
  output logic [IDX_W-1:0]  read_index_2,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic              EX_WE,
  input  logic [IDX_W-1:0]  EX_IDX,
  input  logic [DATA_W-1:0] EX_DATA,
  input  logic              EX_IS_LOAD,
  input  logic              MEM_WE,
  input  logic [IDX_W-1:0]  MEM_IDX,
  input  logic [DATA_W-1:0] MEM_DATA,
  input  logic              STALL_IN,
  input  logic              FLUSH_IN,
  output logic              STALL_IF,
  output logic              VALID_ID,
  output logic [DATA_W-1:0] NPC_ID,
  output logic [DATA_W-1:0] REG1_DATA_ID,
  output logic [DATA_W-1:0] REG2_DATA_ID,
  output logic [DATA_W-1:0] IMM_ID,
  output logic [IDX_W-1:0]  DEST_REG_INDEX_ID,
  output logic [OP_W-1:0]   CTRL_ID,
  output logic              BRANCH_PRED_ID
);

  localparam logic [1:0] BUBBLE_INIT = 2'(LOAD_BUBBLES - 1);

  logic [OP_W-1:0]   opcode;
  logic [IDX_W-1:0]  rs1;
  logic [IDX_W-1:0]  rd;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] opnd1;
  logic [DATA_W-1:0] opnd2;
  logic [DATA_W-1:0] imm_sext;
  logic              haz;
  logic [1:0]        bubble_cnt;

  assign opcode   = INST_IF[INST_W-1 -: OP_W];
  assign rs1      = INST_IF[2*IDX_W-1:IDX_W];
  assign rd       = INST_IF[IDX_W-1:0];
  assign imm      = INST_IF[IDX_W +: IMM_W];
  assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  assign read_index_1 = rs1;
  assign read_index_2 = rd;

  // A load in EX has no data yet, so it is never a forwarding source.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [IDX_W-1:0]  idx,
    input logic [DATA_W-1:0] rf_data,
    input logic              ex_we,
    input logic [IDX_W-1:0]  ex_idx,
    input logic [DATA_W-1:0] ex_data,
    input logic              ex_is_load,
    input logic              mem_we,
    input logic [IDX_W-1:0]  mem_idx,
    input logic [DATA_W-1:0] mem_data
  );
    logic [DATA_W-1:0] sel;
    sel = rf_data;
    if (idx != '0) begin
      if (ex_we && (ex_idx == idx) && !ex_is_load)
        sel = ex_data;
      else if (mem_we && (mem_idx == idx))
        sel = mem_data;
    end
    return sel;
  endfunction

  always_comb begin
    opnd1 = fwd_sel(rs1, read_data_1, EX_WE, EX_IDX, EX_DATA, EX_IS_LOAD,
                    MEM_WE, MEM_IDX, MEM_DATA);
    opnd2 = fwd_sel(rd, read_data_2, EX_WE, EX_IDX, EX_DATA, EX_IS_LOAD,
                    MEM_WE, MEM_IDX, MEM_DATA);
  end

  assign haz = VALID_IF && EX_IS_LOAD && EX_WE && (EX_IDX != '0) &&
               ((EX_IDX == rs1) || (EX_IDX == rd));

  assign STALL_IF = !reset && !FLUSH_IN && (STALL_IN || haz || (bubble_cnt != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      VALID_ID          <= 1'b0;
      NPC_ID            <= '0;
      REG1_DATA_ID      <= '0;
      REG2_DATA_ID      <= '0;
      IMM_ID            <= '0;
      DEST_REG_INDEX_ID <= '0;
      CTRL_ID           <= '0;
      BRANCH_PRED_ID    <= 1'b0;
      bubble_cnt        <= '0;
    end else if (FLUSH_IN) begin
      VALID_ID   <= 1'b0;
      bubble_cnt <= '0;
    end else if (!STALL_IN) begin
      if (haz || (bubble_cnt != '0)) begin
        // Bubble: data registers hold, only the valid bit drops.
        VALID_ID   <= 1'b0;
        bubble_cnt <= (bubble_cnt != '0) ? bubble_cnt - 2'd1 : BUBBLE_INIT;
      end else begin
        VALID_ID          <= VALID_IF;
        NPC_ID            <= NPC_IF;
        REG1_DATA_ID      <= opnd1;
        REG2_DATA_ID      <= opnd2;
        IMM_ID            <= imm_sext;
        DEST_REG_INDEX_ID <= rd;
        CTRL_ID           <= opcode;
        BRANCH_PRED_ID    <= BRANCH_PRED_IF;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_fwd.sv
// Scoreboard bench for decode_stage_fwd: directed scenarios then random traffic,
// checked against an instruction-level reference model.
module tb_decode_stage_fwd;

  localparam int INST_W = 16;
  localparam int DATA_W = 16;
  localparam int OP_W   = 4;
  localparam int IDX_W  = 5;
  localparam int IMM_W  = 7;
  localparam int LB     = 2;

  logic              clk;
  logic              reset;
  logic              VALID_IF;
  logic [DATA_W-1:0] NPC_IF;
  logic [INST_W-1:0] INST_IF;
  logic              BRANCH_PRED_IF;
  logic [IDX_W-1:0]  read_index_1;
  logic [IDX_W-1:0]  read_index_2;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic              EX_WE;
  logic [IDX_W-1:0]  EX_IDX;
  logic [DATA_W-1:0] EX_DATA;
  logic              EX_IS_LOAD;
  logic              MEM_WE;
  logic [IDX_W-1:0]  MEM_IDX;
  logic [DATA_W-1:0] MEM_DATA;
  logic              STALL_IN;
  logic              FLUSH_IN;
  logic              STALL_IF;
  logic              VALID_ID;
  logic [DATA_W-1:0] NPC_ID;
  logic [DATA_W-1:0] REG1_DATA_ID;
  logic [DATA_W-1:0] REG2_DATA_ID;
  logic [DATA_W-1:0] IMM_ID;
  logic [IDX_W-1:0]  DEST_REG_INDEX_ID;
  logic [OP_W-1:0]   CTRL_ID;
  logic              BRANCH_PRED_ID;

  decode_stage_fwd #(
    .INST_W(INST_W), .DATA_W(DATA_W), .OP_W(OP_W), .IDX_W(IDX_W),
    .IMM_W(IMM_W), .LOAD_BUBBLES(LB)
  ) dut (
    .clk(clk), .reset(reset), .VALID_IF(VALID_IF), .NPC_IF(NPC_IF),
    .INST_IF(INST_IF), .BRANCH_PRED_IF(BRANCH_PRED_IF),
    .read_index_1(read_index_1), .read_index_2(read_index_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .EX_WE(EX_WE), .EX_IDX(EX_IDX), .EX_DATA(EX_DATA), .EX_IS_LOAD(EX_IS_LOAD),
    .MEM_WE(MEM_WE), .MEM_IDX(MEM_IDX), .MEM_DATA(MEM_DATA),
    .STALL_IN(STALL_IN), .FLUSH_IN(FLUSH_IN), .STALL_IF(STALL_IF),
    .VALID_ID(VALID_ID), .NPC_ID(NPC_ID), .REG1_DATA_ID(REG1_DATA_ID),
    .REG2_DATA_ID(REG2_DATA_ID), .IMM_ID(IMM_ID),
    .DEST_REG_INDEX_ID(DEST_REG_INDEX_ID), .CTRL_ID(CTRL_ID),
    .BRANCH_PRED_ID(BRANCH_PRED_ID)
  );

  typedef struct packed {
    logic [DATA_W-1:0] npc;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [DATA_W-1:0] imm;
    logic [IDX_W-1:0]  dest;
    logic [OP_W-1:0]   ctrl;
    logic              bp;
  } id_t;

  id_t  sb[$];
  int   errors = 0;
  int   checks = 0;
  int   bub = 0;
  bit   exp_valid = 0;
  logic last_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int field(input int word, input int lo, input int w);
    return (word >> lo) % (1 << w);
  endfunction

  function automatic logic [DATA_W-1:0] pick(input int idx, input logic [DATA_W-1:0] rf);
    if (idx != 0 && EX_WE && int'(EX_IDX) == idx && !EX_IS_LOAD) return EX_DATA;
    if (idx != 0 && MEM_WE && int'(MEM_IDX) == idx) return MEM_DATA;
    return rf;
  endfunction

  function automatic id_t decode_ref();
    id_t d;
    int  w;
    int  imm;
    w   = int'(INST_IF);
    imm = field(w, IDX_W, IMM_W);
    if (imm >= (1 << (IMM_W - 1))) imm -= (1 << IMM_W);
    d.npc  = NPC_IF;
    d.r1   = pick(field(w, IDX_W, IDX_W), read_data_1);
    d.r2   = pick(field(w, 0, IDX_W), read_data_2);
    d.imm  = DATA_W'(imm);
    d.dest = IDX_W'(field(w, 0, IDX_W));
    d.ctrl = OP_W'(field(w, INST_W - OP_W, OP_W));
    d.bp   = BRANCH_PRED_IF;
    return d;
  endfunction

  // Called at posedge+1 with inputs applied; checks combinational outputs,
  // advances the reference model over the coming edge, returns at posedge+1.
  task automatic cycle();
    int rs1;
    int rd;
    bit haz;
    bit exp_stall;
    #1;
    rs1 = field(int'(INST_IF), IDX_W, IDX_W);
    rd  = field(int'(INST_IF), 0, IDX_W);
    haz = VALID_IF && EX_IS_LOAD && EX_WE && EX_IDX != 0 &&
          (int'(EX_IDX) == rs1 || int'(EX_IDX) == rd);
    exp_stall = !reset && !FLUSH_IN && (STALL_IN || haz || bub != 0);
    last_stall = STALL_IF;
    check("stall_if", STALL_IF, exp_stall);
    check("read_index_1", read_index_1, rs1);
    check("read_index_2", read_index_2, rd);
    if (!reset) check("valid_id", VALID_ID, exp_valid);
    if (reset) begin
      exp_valid = 0;
      bub = 0;
    end else if (FLUSH_IN) begin
      if (exp_valid && STALL_IN) sb.delete(sb.size() - 1);
      exp_valid = 0;
      bub = 0;
    end else if (!STALL_IN) begin
      if (haz || bub != 0) begin
        exp_valid = 0;
        bub = (bub != 0) ? bub - 1 : LB - 1;
      end else begin
        exp_valid = VALID_IF;
        if (VALID_IF) sb.push_back(decode_ref());
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Downstream consumes the ID/EX contents on an edge where it is valid and not stalled.
  always @(negedge clk) begin
    id_t g;
    id_t e;
    if (!reset && VALID_ID && !STALL_IN) begin
      g.npc = NPC_ID; g.r1 = REG1_DATA_ID; g.r2 = REG2_DATA_ID; g.imm = IMM_ID;
      g.dest = DEST_REG_INDEX_ID; g.ctrl = CTRL_ID; g.bp = BRANCH_PRED_ID;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected instruction %h, expected none", g);
      end else begin
        e = sb.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL scoreboard: got %h expected %h", g, e);
        end
      end
    end
  end

  task automatic idle();
    VALID_IF = 0; BRANCH_PRED_IF = 0; EX_WE = 0; EX_IDX = '0; EX_IS_LOAD = 0;
    MEM_WE = 0; MEM_IDX = '0; STALL_IN = 0; FLUSH_IN = 0;
  endtask

  task automatic randomize_inputs();
    logic [INST_W-1:0] w;
    w = INST_W'($urandom);
    w[2*IDX_W-1:IDX_W] = IDX_W'($urandom_range(0, 3));
    w[IDX_W-1:0]       = IDX_W'($urandom_range(0, 3));
    INST_IF        = w;
    VALID_IF       = ($urandom_range(0, 9) < 8);
    NPC_IF         = DATA_W'($urandom);
    BRANCH_PRED_IF = 1'($urandom);
    read_data_1    = DATA_W'($urandom);
    read_data_2    = DATA_W'($urandom);
    EX_WE          = 1'($urandom);
    EX_IDX         = IDX_W'($urandom_range(0, 3));
    EX_DATA        = DATA_W'($urandom);
    EX_IS_LOAD     = ($urandom_range(0, 9) < 3);
    MEM_WE         = 1'($urandom);
    MEM_IDX        = IDX_W'($urandom_range(0, 3));
    MEM_DATA       = DATA_W'($urandom);
    STALL_IN       = ($urandom_range(0, 99) < 15);
    FLUSH_IN       = ($urandom_range(0, 99) < 5);
  endtask

  initial begin
    reset = 1;
    randomize_inputs();
    repeat (2) cycle();
    check("rst valid_id", VALID_ID, 0);
    check("rst npc_id", NPC_ID, 0);
    check("rst reg1", REG1_DATA_ID, 0);
    check("rst reg2", REG2_DATA_ID, 0);
    check("rst imm", IMM_ID, 0);
    check("rst dest", DEST_REG_INDEX_ID, 0);
    check("rst ctrl", CTRL_ID, 0);
    check("rst bp", BRANCH_PRED_ID, 0);
    reset = 0;
    idle();
    cycle();

    // Field decode with no forwarding
    VALID_IF = 1; INST_IF = 16'h3A45; NPC_IF = 16'h0100;
    read_data_1 = 16'h1111; read_data_2 = 16'h2222;
    cycle();
    check("dec ctrl", CTRL_ID, 3);
    check("dec imm", IMM_ID, 16'hFFD2);
    check("dec dest", DEST_REG_INDEX_ID, 5);
    check("dec read_index_1", read_index_1, 18);
    check("dec reg1", REG1_DATA_ID, 16'h1111);
    check("dec reg2", REG2_DATA_ID, 16'h2222);

    // Forwarding priority
    INST_IF = 16'h1060; read_data_1 = 16'h1234;
    EX_WE = 1; EX_IDX = 3; EX_DATA = 16'hBEEF;
    MEM_WE = 1; MEM_IDX = 3; MEM_DATA = 16'h0BAD;
    cycle();
    check("fwd ex", REG1_DATA_ID, 16'hBEEF);
    EX_IDX = 0;
    cycle();
    check("fwd mem", REG1_DATA_ID, 16'h0BAD);
    EX_IDX = 3; INST_IF = 16'h1000;
    cycle();
    check("fwd idx0", REG1_DATA_ID, 16'h1234);

    // Load-use with two bubbles; the load result then arrives from MEM
    idle();
    VALID_IF = 1; INST_IF = 16'h2060; NPC_IF = 16'h0200; read_data_1 = 16'h5555;
    EX_WE = 1; EX_IS_LOAD = 1; EX_IDX = 3; EX_DATA = 16'hDEAD;
    cycle();
    check("lu stall1", last_stall, 1);
    check("lu bubble1", VALID_ID, 0);
    EX_WE = 0; EX_IS_LOAD = 0; MEM_WE = 1; MEM_IDX = 3; MEM_DATA = 16'hC0DE;
    cycle();
    check("lu stall2", last_stall, 1);
    check("lu bubble2", VALID_ID, 0);
    cycle();
    check("lu issue stall", last_stall, 0);
    check("lu issue valid", VALID_ID, 1);
    check("lu issue reg1", REG1_DATA_ID, 16'hC0DE);
    check("lu issue npc", NPC_ID, 16'h0200);

    // Flush beats stall and hazard
    idle();
    VALID_IF = 1; INST_IF = 16'h4021; NPC_IF = 16'h0400;
    cycle();
    STALL_IN = 1; FLUSH_IN = 1; EX_WE = 1; EX_IS_LOAD = 1; EX_IDX = 1;
    cycle();
    check("flush stall_if", last_stall, 0);
    check("flush valid", VALID_ID, 0);
    idle();
    VALID_IF = 1; INST_IF = 16'h5021; NPC_IF = 16'h0500;
    cycle();
    check("flush cnt clear", last_stall, 0);
    check("flush next valid", VALID_ID, 1);

    // Downstream stall for three cycles mid-stream
    INST_IF = 16'h6043; NPC_IF = 16'h0600;
    cycle();
    INST_IF = 16'h7065; NPC_IF = 16'h0700; STALL_IN = 1;
    repeat (3) begin
      cycle();
      check("stall hold npc", NPC_ID, 16'h0600);
      check("stall hold valid", VALID_ID, 1);
      check("stall stall_if", last_stall, 1);
    end
    STALL_IN = 0;
    cycle();
    check("stall resume npc", NPC_ID, 16'h0700);

    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      cycle();
    end

    idle();
    repeat (5) cycle();
    check("sb drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
